// File: rtl/sync_fifo.sv
// Single-clock FIFO of DEPTH x DWIDTH words with a registered read port.
// Pointers wrap explicitly, so DEPTH does not have to be a power of two.
module sync_fifo #(
    parameter int DWIDTH = 32,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              write,
    input  logic [DWIDTH-1:0] din,
    output logic              full,
    input  logic              read,
    output logic [DWIDTH-1:0] dout,
    output logic              empty
);
    localparam int PW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);

    logic [DWIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [DWIDTH-1:0] dout_q, dout_d;
    logic              wr_en, rd_en;

    assign empty = (count_q == '0);
    assign full  = (count_q == DEPTH_C);
    assign dout  = dout_q;

    always_comb begin
        // full gates the write even when a read frees a slot in the same cycle
        wr_en    = write & ~full;
        rd_en    = read & ~empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        dout_d   = dout_q;
        if (wr_en) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
        if (rd_en) begin
            rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
            dout_d   = mem_q[rd_ptr_q];
        end
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            dout_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            dout_q   <= dout_d;
        end
    end

    // Storage is never cleared; stale words are unreachable once count is zero.
    always_ff @(posedge clk) begin
        if (!rst && wr_en) mem_q[wr_ptr_q] <= din;
    end
endmodule

// File: tb/tb_sync_fifo.sv
// Randomized and directed bench for sync_fifo against a queue-based model.
module tb_sync_fifo;
    localparam int DWIDTH = 32;
    localparam int DEPTH  = 16;

    logic              clk = 1'b0;
    logic              rst, write, read;
    logic [DWIDTH-1:0] din;
    logic              full, empty;
    logic [DWIDTH-1:0] dout;

    int checks = 0;
    int errors = 0;

    logic [DWIDTH-1:0] q_m [$];
    logic [DWIDTH-1:0] dout_m;

    sync_fifo #(.DWIDTH(DWIDTH), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .write (write),
        .din   (din),
        .full  (full),
        .read  (read),
        .dout  (dout),
        .empty (empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Drive one cycle, advance the model by the FIFO rules, then check outputs.
    task automatic step(input logic rs, input logic w, input logic r,
                        input logic [DWIDTH-1:0] d, input string tag);
        bit wacc, racc;
        rst = rs; write = w; read = r; din = d;
        @(posedge clk);
        if (rs) begin
            q_m.delete();
            dout_m = '0;
        end else begin
            wacc = w && (q_m.size() < DEPTH);
            racc = r && (q_m.size() > 0);
            if (racc) dout_m = q_m.pop_front();
            if (wacc) q_m.push_back(d);
        end
        #1;
        chk({tag, ".empty"}, 64'(empty), 64'(q_m.size() == 0));
        chk({tag, ".full"},  64'(full),  64'(q_m.size() == DEPTH));
        chk({tag, ".dout"},  64'(dout),  64'(dout_m));
    endtask

    initial begin
        int nxt, exp_rd, sz;
        rst = 1'b1; write = 1'b0; read = 1'b0; din = '0; dout_m = '0;

        for (int i = 0; i < 10; i++) step(1, 0, 0, '0, "reset");
        step(0, 0, 1, '0, "rd_empty");
        chk("rd_empty.dout0", 64'(dout), 64'h0);

        for (int i = 0; i < DEPTH; i++) step(0, 1, 0, DWIDTH'(i), "fill");
        chk("fill.full_now", 64'(full), 64'h1);
        step(0, 1, 0, 32'h99, "overflow");

        for (int i = 0; i < DEPTH; i++) begin
            step(0, 0, 1, '0, "drain");
            chk("drain.order", 64'(dout), 64'(i));
        end
        chk("drain.empty_now", 64'(empty), 64'h1);
        step(0, 0, 1, '0, "overdrain");
        chk("overdrain.hold", 64'(dout), 64'd15);

        // Simultaneous read/write at count 5, at full and at empty
        for (int i = 0; i < 5; i++) step(0, 1, 0, DWIDTH'(32'h100 + i), "pre5");
        step(0, 1, 1, 32'h1AA, "rw5");
        chk("rw5.oldest", 64'(dout), 64'h100);
        sz = q_m.size();
        chk("rw5.count", 64'(sz), 64'd5);
        while (!full) step(0, 1, 0, DWIDTH'($urandom), "tofull");
        step(0, 1, 1, 32'hBEEF, "rwfull");
        chk("rwfull.not_full", 64'(full), 64'h0);
        while (!empty) step(0, 0, 1, '0, "toempty");
        step(0, 1, 1, 32'hC0DE, "rwempty");
        chk("rwempty.not_empty", 64'(empty), 64'h0);
        step(0, 0, 1, '0, "rwempty_pop");
        chk("rwempty.word", 64'(dout), 64'hC0DE);

        // Wrap-around streaming with delayed, throttled reads
        nxt = 0; exp_rd = 0;
        for (int cyc = 0; cyc < 300 && exp_rd < 100; cyc++) begin
            bit w, r;
            w = (nxt < 100) && !full;
            r = (cyc >= 90) && !empty;
            step(0, w, r, DWIDTH'(nxt), "stream");
            if (w) nxt++;
            if (r) begin
                chk("stream.seq", 64'(dout), 64'(exp_rd));
                exp_rd++;
            end
        end
        chk("stream.all_read", 64'(exp_rd), 64'd100);

        // Mid-operation reset
        for (int i = 0; i < 7; i++) step(0, 1, 0, DWIDTH'(i + 50), "pre_rst");
        step(1, 1, 1, 32'hDEAD, "mid_rst");
        chk("mid_rst.dout0", 64'(dout), 64'h0);
        step(0, 1, 0, 32'hA5, "post_rst_wr");
        step(0, 0, 1, '0, "post_rst_rd");
        chk("post_rst.a5", 64'(dout), 64'hA5);
        step(0, 0, 1, '0, "post_rst_empty");

        // Random traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            int mode;
            mode = (i / 250) % 3;
            step(($urandom_range(0, 299) == 0),
                 ($urandom_range(0, 9) < (mode == 0 ? 7 : (mode == 1 ? 3 : 5))),
                 ($urandom_range(0, 9) < (mode == 0 ? 3 : (mode == 1 ? 7 : 5))),
                 DWIDTH'($urandom), "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
